bcd_tick_counter: RTL and testbench

Four-digit BCD up/down event counter with a multiplexed seven-segment driver, placed directly downstream of the selectable-rate divider. The divider's `clk_hz` square wave is treated as data, not as a clock: it is synchronised into the `clk_50mhz` domain and edge-detected, and each rising edge advances the count. The count is shown on a four-digit common-anode display by time-multiplexed scanning.

---
 rtl/bcd_tick_counter.sv | 191 +++++++++++++++++++
 tb/tb_bcd_tick_counter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_tick_counter.sv
// Four-digit BCD up/down counter stepped by rising edges of a synchronised clk_hz,
// with a multiplexed common-anode seven-segment scanner. Define BCD_BLANK_EN for leading-zero blanking.
module bcd_tick_counter #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk_50mhz,
  input  logic        rst,
  input  logic        clk_hz,
  input  logic        en,
  input  logic        up,
  input  logic        clr,
  output logic [15:0] bcd,
  output logic        tick,
  output logic        carry,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {SCAN0 = 2'd0, SCAN1 = 2'd1, SCAN2 = 2'd2, SCAN3 = 2'd3} scan_state_t;

  logic             s0_r, s1_r, s1_d_r;
  logic             hz_edge_s;
  logic [15:0]      bcd_r, bcd_step_s;
  logic             ripple_s;
  logic             tick_r, carry_r;
  logic [CW-1:0]    slot_cnt_r;
  scan_state_t      state_r, state_nxt_s;
  logic [3:0]       an_r, an_nxt_s;
  logic [6:0]       seg_r, seg_nxt_s;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  function automatic logic [3:0] digit_sel(input logic [15:0] v, input logic [1:0] k);
    case (k)
      2'd0:    digit_sel = v[3:0];
      2'd1:    digit_sel = v[7:4];
      2'd2:    digit_sel = v[11:8];
      2'd3:    digit_sel = v[15:12];
      default: digit_sel = 4'd0;
    endcase
  endfunction

  // True when digit k and every higher digit are zero; the ones digit never qualifies.
  function automatic logic lead_zero(input logic [15:0] v, input logic [1:0] k);
    case (k)
      2'd3:    lead_zero = (v[15:12] == 4'd0);
      2'd2:    lead_zero = (v[15:8] == 8'd0);
      2'd1:    lead_zero = (v[15:4] == 12'd0);
      default: lead_zero = 1'b0;
    endcase
  endfunction

  // clk_hz synchroniser and delay stage for rising-edge detection
  always_ff @(posedge clk_50mhz or negedge rst) begin
    if (!rst) begin
      s0_r   <= 1'b0;
      s1_r   <= 1'b0;
      s1_d_r <= 1'b0;
    end else begin
      s0_r   <= clk_hz;
      s1_r   <= s0_r;
      s1_d_r <= s1_r;
    end
  end

  assign hz_edge_s = s1_r & ~s1_d_r;

  // Ripple BCD step; ripple_s left set after the top digit means wrap-around
  always_comb begin
    bcd_step_s = bcd_r;
    ripple_s   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (ripple_s) begin
        if (up) begin
          if (bcd_r[4*i +: 4] == 4'd9) begin
            bcd_step_s[4*i +: 4] = 4'd0;
            ripple_s             = 1'b1;
          end else begin
            bcd_step_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd1;
            ripple_s             = 1'b0;
          end
        end else begin
          if (bcd_r[4*i +: 4] == 4'd0) begin
            bcd_step_s[4*i +: 4] = 4'd9;
            ripple_s             = 1'b1;
          end else begin
            bcd_step_s[4*i +: 4] = bcd_r[4*i +: 4] - 4'd1;
            ripple_s             = 1'b0;
          end
        end
      end else begin
        ripple_s = 1'b0;
      end
    end
  end

  // Count register with clear priority over a coincident edge
  always_ff @(posedge clk_50mhz or negedge rst) begin
    if (!rst) begin
      bcd_r   <= 16'h0000;
      tick_r  <= 1'b0;
      carry_r <= 1'b0;
    end else if (clr) begin
      bcd_r   <= 16'h0000;
      tick_r  <= 1'b0;
      carry_r <= 1'b0;
    end else if (hz_edge_s && en) begin
      bcd_r   <= bcd_step_s;
      tick_r  <= 1'b1;
      carry_r <= ripple_s;
    end else begin
      tick_r  <= 1'b0;
      carry_r <= 1'b0;
    end
  end

  // Scan next state plus the digit-select and segment pattern for that state
  always_comb begin
    state_nxt_s = state_r;
    if (slot_cnt_r == SLOT_LAST) begin
      case (state_r)
        SCAN0:   state_nxt_s = SCAN1;
        SCAN1:   state_nxt_s = SCAN2;
        SCAN2:   state_nxt_s = SCAN3;
        SCAN3:   state_nxt_s = SCAN0;
        default: state_nxt_s = SCAN0;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
    case (state_nxt_s)
      SCAN0:   an_nxt_s = 4'b1110;
      SCAN1:   an_nxt_s = 4'b1101;
      SCAN2:   an_nxt_s = 4'b1011;
      SCAN3:   an_nxt_s = 4'b0111;
      default: an_nxt_s = 4'b1110;
    endcase
`ifdef BCD_BLANK_EN
    if (lead_zero(bcd_r, state_nxt_s)) begin
      seg_nxt_s = 7'b1111111;
    end else begin
      seg_nxt_s = seg_decode(digit_sel(bcd_r, state_nxt_s));
    end
`else
    seg_nxt_s = seg_decode(digit_sel(bcd_r, state_nxt_s));
`endif
  end

  // Slot counter, scan state and registered display outputs
  always_ff @(posedge clk_50mhz or negedge rst) begin
    if (!rst) begin
      slot_cnt_r <= '0;
      state_r    <= SCAN0;
      an_r       <= 4'b1110;
      seg_r      <= 7'b1000000;
    end else begin
      if (slot_cnt_r == SLOT_LAST) begin
        slot_cnt_r <= '0;
      end else begin
        slot_cnt_r <= slot_cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
      state_r <= state_nxt_s;
      an_r    <= an_nxt_s;
      seg_r   <= seg_nxt_s;
    end
  end

  assign bcd   = bcd_r;
  assign tick  = tick_r;
  assign carry = carry_r;
  assign an    = an_r;
  assign seg   = seg_r;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Directed self-checking bench for bcd_tick_counter (SCAN_DIV = 4); expected values hand-computed.
module tb_bcd_tick_counter;

  logic        clk_50mhz = 1'b0;
  logic        rst = 1'b0;
  logic        clk_hz = 1'b0;
  logic        en = 1'b1;
  logic        up = 1'b1;
  logic        clr = 1'b0;
  logic [15:0] bcd;
  logic        tick, carry;
  logic [3:0]  an;
  logic [6:0]  seg;

  int total = 0;
  int bad = 0;
  int tick_cnt = 0;
  int carry_cnt = 0;
  int snap;
  logic t_obs, c_obs;

  bcd_tick_counter #(.SCAN_DIV(4)) dut (
    .clk_50mhz(clk_50mhz), .rst(rst), .clk_hz(clk_hz), .en(en), .up(up), .clr(clr),
    .bcd(bcd), .tick(tick), .carry(carry), .an(an), .seg(seg)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  always @(negedge clk_50mhz) begin
    if (tick === 1'b1) tick_cnt++;
    if (carry === 1'b1) carry_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_50mhz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clk_hz period: rising edge, then sample tick/carry at the step cycle.
  task automatic hz_edge(output logic t, output logic c);
    clk_hz = 1'b1;
    cyc(3);
    t = tick;
    c = carry;
    clk_hz = 1'b0;
    cyc(1);
  endtask

  task automatic align_scan0();
    for (int i = 0; i < 20 && an !== 4'b0111; i++) cyc(1);
    chk("align_scan3", {28'd0, an}, 32'h7);
    for (int i = 0; i < 20 && an !== 4'b1110; i++) cyc(1);
    chk("align_scan0", {28'd0, an}, 32'he);
  endtask

  logic [3:0] an_exp [4];
  logic [6:0] seg_1234 [4];
  logic [6:0] seg_0007 [4];

  initial begin
    an_exp   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_1234 = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
`ifdef BCD_BLANK_EN
    seg_0007 = '{7'b1111000, 7'b1111111, 7'b1111111, 7'b1111111};
`else
    seg_0007 = '{7'b1111000, 7'b1000000, 7'b1000000, 7'b1000000};
`endif

    // reset state
    cyc(3);
    chk("rst_bcd", {16'd0, bcd}, 32'h0);
    chk("rst_tick", {31'd0, tick}, 32'h0);
    chk("rst_carry", {31'd0, carry}, 32'h0);
    chk("rst_an", {28'd0, an}, 32'he);
    chk("rst_seg", {25'd0, seg}, 32'h40);
    rst = 1'b1;
    tick_cnt = 0;
    carry_cnt = 0;

    // first edge: step appears two edges after the sampling edge
    clk_hz = 1'b1;
    cyc(2);
    chk("lat_bcd_n1", {16'd0, bcd}, 32'h0);
    chk("lat_tick_n1", {31'd0, tick}, 32'h0);
    cyc(1);
    chk("lat_bcd_n2", {16'd0, bcd}, 32'h1);
    chk("lat_tick_n2", {31'd0, tick}, 32'h1);
    clk_hz = 1'b0;
    cyc(1);
    chk("tick_one_cycle", {31'd0, tick}, 32'h0);
    repeat (11) hz_edge(t_obs, c_obs);
    chk("up12_bcd", {16'd0, bcd}, 32'h0012);
    chk("up12_ticks", tick_cnt, 32'd12);
    chk("up12_carry", carry_cnt, 32'd0);

    // clr latency, down wrap, preload 9998, up wrap
    clr = 1'b1;
    cyc(1);
    chk("clr_bcd", {16'd0, bcd}, 32'h0);
    clr = 1'b0;
    up = 1'b0;
    hz_edge(t_obs, c_obs);
    chk("dnwrap_bcd", {16'd0, bcd}, 32'h9999);
    chk("dnwrap_carry", {31'd0, c_obs}, 32'h1);
    hz_edge(t_obs, c_obs);
    chk("pre9998_bcd", {16'd0, bcd}, 32'h9998);
    chk("pre9998_carry", {31'd0, c_obs}, 32'h0);
    up = 1'b1;
    carry_cnt = 0;
    hz_edge(t_obs, c_obs);
    chk("up9999_bcd", {16'd0, bcd}, 32'h9999);
    chk("up9999_carry", {31'd0, c_obs}, 32'h0);
    hz_edge(t_obs, c_obs);
    chk("upwrap_bcd", {16'd0, bcd}, 32'h0000);
    chk("upwrap_tick", {31'd0, t_obs}, 32'h1);
    chk("upwrap_carry", {31'd0, c_obs}, 32'h1);
    chk("upwrap_carry_cnt", carry_cnt, 32'd1);

    // down across a digit boundary
    repeat (100) hz_edge(t_obs, c_obs);
    chk("up100_bcd", {16'd0, bcd}, 32'h0100);
    up = 1'b0;
    hz_edge(t_obs, c_obs);
    chk("dn0099_bcd", {16'd0, bcd}, 32'h0099);
    chk("dn0099_carry", {31'd0, c_obs}, 32'h0);

    // clr wins over a coincident edge
    snap = tick_cnt;
    clk_hz = 1'b1;
    cyc(2);
    clr = 1'b1;
    cyc(1);
    chk("clr_edge_bcd", {16'd0, bcd}, 32'h0);
    chk("clr_edge_tick", {31'd0, tick}, 32'h0);
    clr = 1'b0;
    clk_hz = 1'b0;
    cyc(3);
    chk("clr_edge_hold", {16'd0, bcd}, 32'h0);
    chk("clr_edge_ticks", tick_cnt, snap);

    // pause: edges dropped, en rise does not count
    up = 1'b1;
    repeat (3) hz_edge(t_obs, c_obs);
    chk("pre_pause_bcd", {16'd0, bcd}, 32'h0003);
    en = 1'b0;
    snap = tick_cnt;
    repeat (5) hz_edge(t_obs, c_obs);
    chk("pause_bcd", {16'd0, bcd}, 32'h0003);
    chk("pause_ticks", tick_cnt, snap);
    clk_hz = 1'b1;
    cyc(3);
    en = 1'b1;
    cyc(3);
    chk("en_rise_bcd", {16'd0, bcd}, 32'h0003);
    chk("en_rise_ticks", tick_cnt, snap);
    clk_hz = 1'b0;
    cyc(2);

    // scan with bcd = 1234
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    repeat (1234) hz_edge(t_obs, c_obs);
    chk("pre_scan_bcd", {16'd0, bcd}, 32'h1234);
    align_scan0();
    for (int s = 0; s < 4; s++) begin
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("scan_an_s%0d_c%0d", s, j), {28'd0, an}, {28'd0, an_exp[s]});
        chk($sformatf("scan_seg_s%0d_c%0d", s, j), {25'd0, seg}, {25'd0, seg_1234[s]});
        cyc(1);
      end
    end
    chk("scan_frame_wrap", {28'd0, an}, 32'he);

    // scan with bcd = 0007 (leading zeros blanked only with BCD_BLANK_EN)
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    repeat (7) hz_edge(t_obs, c_obs);
    align_scan0();
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("s7_an_s%0d", s), {28'd0, an}, {28'd0, an_exp[s]});
      chk($sformatf("s7_seg_s%0d", s), {25'd0, seg}, {25'd0, seg_0007[s]});
      cyc(4);
    end

    // asynchronous reset mid-scan and mid-count
    for (int i = 0; i < 20 && an !== 4'b1101; i++) cyc(1);
    chk("pre_rst_an", {28'd0, an}, 32'hd);
    clk_hz = 1'b1;
    cyc(1);
    #5;
    rst = 1'b0;
    #1;
    chk("arst_bcd", {16'd0, bcd}, 32'h0);
    chk("arst_tick", {31'd0, tick}, 32'h0);
    chk("arst_carry", {31'd0, carry}, 32'h0);
    chk("arst_an", {28'd0, an}, 32'he);
    chk("arst_seg", {25'd0, seg}, 32'h40);
    clk_hz = 1'b0;
    cyc(1);
    rst = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("post_rst_an_c%0d", j), {28'd0, an}, 32'he);
      cyc(1);
    end
    chk("post_rst_scan1", {28'd0, an}, 32'hd);
    chk("post_rst_bcd", {16'd0, bcd}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
